// File: rtl/wcol_enc_pkg.sv
// -----------------------------------------------------------------------------
// wcol_enc_pkg
// Shared types and constants for the weight-column encoder.
//   GROUP_SIZE       : weights per encode group (one skip-zero flag per group)
//   MUXES_PER_GROUP  : activation muxes available to one group
//   state_t          : encoder FSM states
//   grp_enc_t        : result of encoding one group's 8 column bits
// -----------------------------------------------------------------------------
package wcol_enc_pkg;

  localparam int GROUP_SIZE      = 8;
  localparam int MUXES_PER_GROUP = 4;
  localparam int NUM_GROUPS      = 2;
  localparam int ENC_SEL_WIDTH   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [MUXES_PER_GROUP-1:0][ENC_SEL_WIDTH-1:0] sel;
    logic [MUXES_PER_GROUP-1:0]                    val;
    logic                                          skip_zero;
  } grp_enc_t;

  function automatic logic [3:0] popcount8(input logic [GROUP_SIZE-1:0] bits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      cnt = cnt + 4'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/wcol_group_enc.sv
// -----------------------------------------------------------------------------
// wcol_group_enc
// Purely combinational encoder for one group of 8 weight bits in one column.
// Chooses the sparser of the one-set / zero-set (at most 4 members) and maps
// each member onto one of 4 activation muxes, each mux covering a sliding
// window of 5 positions (mux k sees positions k..k+4).
// Ports:
//   i_bits : bit `col` of weights 8g..8g+7 (bit i = weight 8g+i)
//   o_enc  : mux selects, mux valids and the skip-zero flag for the group
// -----------------------------------------------------------------------------
module wcol_group_enc
  import wcol_enc_pkg::*;
(
  input  logic [GROUP_SIZE-1:0] i_bits,
  output grp_enc_t              o_enc
);

  always_comb begin
    int         prev_mux;
    int         cand;
    int         mux;
    logic       skip;
    logic [3:0] n;

    o_enc    = '0;
    n        = popcount8(i_bits);
    // Up to 4 ones: encode the ones. More than 4: the zeros are the sparse set.
    skip     = (n <= 4'd4);
    o_enc.skip_zero = skip;
    prev_mux = -1;
    cand     = 0;
    mux      = 0;

    // Scanning positions in ascending order gives the sorted set for free.
    // Greedy placement: the lowest mux that is past the previous one and
    // still has position i inside its 5-wide window.
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (i_bits[i] == skip) begin
        cand = i - 4;
        mux  = prev_mux + 1;
        if (cand > mux) begin
          mux = cand;
        end
        o_enc.val[mux[1:0]] = 1'b1;
        o_enc.sel[mux[1:0]] = ENC_SEL_WIDTH'(i - mux);
        prev_mux = mux;
      end
    end
  end

endmodule

// File: rtl/wcol_encoder.sv
// -----------------------------------------------------------------------------
// wcol_encoder
// Weight-side producer for the vertical bit-column MAC. Captures one vector of
// VEC_LENGTH signed weights, then issues one beat per bit column (MSB first)
// followed by a single drain beat that flushes the MAC's psum stage.
//
// Optional build macro:
//   WGT_ENC_ZERO_COL_SKIP_EN - suppress beats for all-zero columns below the
//                              MSB column (the MSB beat is always issued).
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   i_w_valid        : weight vector valid
//   o_w_ready        : encoder can accept a vector
//   i_w_data         : VEC_LENGTH signed weights
//   o_col_valid      : column beat valid
//   i_col_ready      : MAC consumes the beat
//   o_act_sel        : per-mux select (offset 0..4 in the mux window)
//   o_act_val        : per-mux valid
//   o_is_skip_zero   : per group, 1 = ones encoded, 0 = zeros encoded
//   o_column_idx     : bit column of this beat
//   o_is_msb         : beat is column DATA_WIDTH-1
//   o_en_mul, o_is_shift_mul, o_mul_const : constant-multiplier path, tied 0
//   o_col_first      : first beat of a vector
//   o_col_last       : drain beat of a vector
// -----------------------------------------------------------------------------
module wcol_encoder
  import wcol_enc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = 3,
  parameter int COL_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_w_valid,
  output logic                          o_w_ready,
  input  logic signed [DATA_WIDTH-1:0]  i_w_data [VEC_LENGTH],
  output logic                          o_col_valid,
  input  logic                          i_col_ready,
  output logic [SEL_WIDTH-1:0]          o_act_sel [VEC_LENGTH/2],
  output logic [VEC_LENGTH/2-1:0]       o_act_val,
  output logic [NUM_GROUPS-1:0]         o_is_skip_zero,
  output logic [COL_WIDTH-1:0]          o_column_idx,
  output logic                          o_is_msb,
  output logic                          o_en_mul,
  output logic                          o_is_shift_mul,
  output logic [2:0]                    o_mul_const,
  output logic                          o_col_first,
  output logic                          o_col_last
);

  localparam logic [COL_WIDTH-1:0] COL_MSB = COL_WIDTH'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [COL_WIDTH-1:0]  r_col;
  logic [COL_WIDTH-1:0]  w_col_next;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] r_wbuf [VEC_LENGTH];
  logic [VEC_LENGTH-1:0] w_col_bits;
  grp_enc_t              w_grp_enc [NUM_GROUPS];

  // Current column slice across all weights.
  generate
    for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_col_bits
      assign w_col_bits[gi] = r_wbuf[gi][r_col];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
      wcol_group_enc u_group_enc (
        .i_bits (w_col_bits[gi*GROUP_SIZE +: GROUP_SIZE]),
        .o_enc  (w_grp_enc[gi])
      );
    end
  endgenerate

`ifdef WGT_ENC_ZERO_COL_SKIP_EN
  logic [DATA_WIDTH-1:0] w_col_nz;
  logic                  w_lower_found;
  logic [COL_WIDTH-1:0]  w_lower_col;

  always_comb begin
    w_col_nz = '0;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      for (int v = 0; v < VEC_LENGTH; v++) begin
        w_col_nz[c] = w_col_nz[c] | r_wbuf[v][c];
      end
    end
  end

  // Highest nonzero column strictly below the current one; ascending scan so
  // the last hit wins.
  always_comb begin
    w_lower_found = 1'b0;
    w_lower_col   = '0;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      if ((COL_WIDTH'(c) < r_col) && w_col_nz[c]) begin
        w_lower_found = 1'b1;
        w_lower_col   = COL_WIDTH'(c);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_col   <= '0;
      for (int v = 0; v < VEC_LENGTH; v++) begin
        r_wbuf[v] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      if (w_load) begin
        for (int v = 0; v < VEC_LENGTH; v++) begin
          r_wbuf[v] <= i_w_data[v];
        end
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_col_next     = r_col;
    w_load         = 1'b0;
    o_w_ready      = 1'b0;
    o_col_valid    = 1'b0;
    o_col_first    = 1'b0;
    o_col_last     = 1'b0;
    o_is_msb       = 1'b0;
    o_column_idx   = '0;
    o_act_val      = '0;
    o_is_skip_zero = '1;
    for (int i = 0; i < VEC_LENGTH/2; i++) begin
      o_act_sel[i] = '0;
    end

    case (r_state)
      IDLE: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          w_load       = 1'b1;
          w_col_next   = COL_MSB;
          w_state_next = ISSUE;
        end
      end

      ISSUE: begin
        o_col_valid  = 1'b1;
        o_column_idx = r_col;
        o_is_msb     = (r_col == COL_MSB);
        o_col_first  = (r_col == COL_MSB);
        for (int g = 0; g < NUM_GROUPS; g++) begin
          o_is_skip_zero[g] = w_grp_enc[g].skip_zero;
          for (int k = 0; k < MUXES_PER_GROUP; k++) begin
            o_act_val[g*MUXES_PER_GROUP + k] = w_grp_enc[g].val[k];
            o_act_sel[g*MUXES_PER_GROUP + k] = SEL_WIDTH'(w_grp_enc[g].sel[k]);
          end
        end
        if (i_col_ready) begin
`ifdef WGT_ENC_ZERO_COL_SKIP_EN
          if (w_lower_found) begin
            w_col_next = w_lower_col;
          end else begin
            w_state_next = DRAIN;
          end
`else
          if (r_col == '0) begin
            w_state_next = DRAIN;
          end else begin
            w_col_next = r_col - 1'b1;
          end
`endif
        end
      end

      DRAIN: begin
        o_col_valid = 1'b1;
        o_col_last  = 1'b1;
        if (i_col_ready) begin
          // The drain handshake doubles as an accept slot so consecutive
          // vectors stream without a bubble.
          o_w_ready = 1'b1;
          if (i_w_valid) begin
            w_load       = 1'b1;
            w_col_next   = COL_MSB;
            w_state_next = ISSUE;
          end else begin
            w_state_next = IDLE;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_en_mul       = 1'b0;
  assign o_is_shift_mul = 1'b0;
  assign o_mul_const    = 3'b000;

endmodule

// File: tb/tb_wcol_encoder.sv
// -----------------------------------------------------------------------------
// tb_wcol_encoder
// Directed bench with an expected-beat queue: a reference encode model pushes
// every beat a vector should produce when the vector is driven, and each beat
// the DUT presents is popped and compared.
// -----------------------------------------------------------------------------
module tb_wcol_encoder;

  typedef struct packed {
    logic [4:0]  tied;
    logic        last;
    logic        first;
    logic        msb;
    logic [2:0]  idx;
    logic [1:0]  skip;
    logic [7:0]  val;
    logic [23:0] sel;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_w_valid;
  logic              o_w_ready;
  logic signed [7:0] i_w_data [16];
  logic              o_col_valid;
  logic              i_col_ready;
  logic [2:0]        o_act_sel [8];
  logic [7:0]        o_act_val;
  logic [1:0]        o_is_skip_zero;
  logic [2:0]        o_column_idx;
  logic              o_is_msb;
  logic              o_en_mul;
  logic              o_is_shift_mul;
  logic [2:0]        o_mul_const;
  logic              o_col_first;
  logic              o_col_last;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  beat_t obs_col [8];
  logic [7:0] wv [16];

  wcol_encoder #(
    .DATA_WIDTH (8),
    .VEC_LENGTH (16),
    .SEL_WIDTH  (3),
    .COL_WIDTH  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_w_valid      (i_w_valid),
    .o_w_ready      (o_w_ready),
    .i_w_data       (i_w_data),
    .o_col_valid    (o_col_valid),
    .i_col_ready    (i_col_ready),
    .o_act_sel      (o_act_sel),
    .o_act_val      (o_act_val),
    .o_is_skip_zero (o_is_skip_zero),
    .o_column_idx   (o_column_idx),
    .o_is_msb       (o_is_msb),
    .o_en_mul       (o_en_mul),
    .o_is_shift_mul (o_is_shift_mul),
    .o_mul_const    (o_mul_const),
    .o_col_first    (o_col_first),
    .o_col_last     (o_col_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encode of one column of a weight vector.
  function automatic beat_t model_beat(input logic [7:0] w [16], input int c);
    beat_t      b;
    logic [7:0] bits;
    int         n;
    logic       skip;
    int         m;
    int         lo;
    b = '0;
    b.first = (c == 7);
    b.msb   = (c == 7);
    b.idx   = 3'(c);
    for (int g = 0; g < 2; g++) begin
      n = 0;
      for (int i = 0; i < 8; i++) begin
        bits[i] = w[8*g + i][c];
        n += int'(bits[i]);
      end
      skip = (n <= 4);
      b.skip[g] = skip;
      m = -1;
      for (int p = 0; p < 8; p++) begin
        if (bits[p] == skip) begin
          lo = p - 4;
          m  = (m + 1 > lo) ? m + 1 : lo;
          b.val[4*g + m] = 1'b1;
          b.sel[3*(4*g + m) +: 3] = 3'(p - m);
        end
      end
    end
    return b;
  endfunction

  function automatic beat_t drain_beat();
    beat_t b;
    b = '0;
    b.last = 1'b1;
    b.skip = 2'b11;
    return b;
  endfunction

  function automatic beat_t observe();
    beat_t b;
    b.tied  = {o_en_mul, o_is_shift_mul, o_mul_const};
    b.last  = o_col_last;
    b.first = o_col_first;
    b.msb   = o_is_msb;
    b.idx   = o_column_idx;
    b.skip  = o_is_skip_zero;
    b.val   = o_act_val;
    for (int i = 0; i < 8; i++) begin
      b.sel[3*i +: 3] = o_act_sel[i];
    end
    return b;
  endfunction

  task automatic push_vector(input logic [7:0] w [16]);
    logic col_zero;
    for (int c = 7; c >= 0; c--) begin
      col_zero = 1'b1;
      for (int v = 0; v < 16; v++) begin
        if (w[v][c]) col_zero = 1'b0;
      end
`ifdef WGT_ENC_ZERO_COL_SKIP_EN
      if (c != 7 && col_zero) continue;
`endif
      exp_q.push_back(model_beat(w, c));
    end
    exp_q.push_back(drain_beat());
  endtask

  task automatic check_beat(input string tag, input beat_t obs, input beat_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive wv as one vector; returns at the negedge after the accepting edge.
  task automatic load();
    int t;
    t = 0;
    while (o_w_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("load_w_ready", 32'(o_w_ready), 32'd1);
    i_w_valid = 1'b1;
    for (int v = 0; v < 16; v++) i_w_data[v] = wv[v];
    push_vector(wv);
    @(negedge clk);
    i_w_valid = 1'b0;
  endtask

  // Consume n beats; optionally stall 3 cycles on the beat for stall_col.
  task automatic consume(input int n, input int stall_col);
    int    t;
    beat_t e;
    beat_t o;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (o_col_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      check_val("beat_valid", 32'(o_col_valid), 32'd1);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_queue observed=beat expected=none");
        return;
      end
      e = exp_q.pop_front();
      o = observe();
      check_beat($sformatf("beat_col%0d_last%0d", e.idx, e.last), o, e);
      $display("beat idx=%0d first=%0d last=%0d skip=%b val=%b sel=%h",
               o.idx, o.first, o.last, o.skip, o.val, o.sel);
      if (!e.last) obs_col[e.idx] = o;
      if (!e.last && stall_col == int'(e.idx)) begin
        i_col_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_beat("stall_hold", observe(), e);
        end
        i_col_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    beat_t rst_b;
    int    t;
    beat_t e;

    reset       = 1'b1;
    i_w_valid   = 1'b0;
    i_col_ready = 1'b1;
    for (int v = 0; v < 16; v++) i_w_data[v] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    rst_b      = '0;
    rst_b.skip = 2'b11;
    check_beat("reset_outputs", observe(), rst_b);
    check_val("reset_col_valid", 32'(o_col_valid), 32'd0);
    check_val("reset_w_ready", 32'(o_w_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // All weights 0x01
    for (int v = 0; v < 16; v++) wv[v] = 8'h01;
    load();
    check_val("first_beat_latency", 32'(o_col_valid), 32'd1);
    consume(exp_q.size(), -1);
    check_val("ones_col0_skip", 32'(obs_col[0].skip), 32'h0);
    check_val("ones_col0_val", 32'(obs_col[0].val), 32'h0);
    check_val("ones_col7_skip", 32'(obs_col[7].skip), 32'h3);
    check_val("ones_col7_val", 32'(obs_col[7].val), 32'h0);

    // w[0] = -128
    for (int v = 0; v < 16; v++) wv[v] = 8'h00;
    wv[0] = 8'h80;
    load();
    consume(exp_q.size(), -1);
    check_val("msb_first", 32'({obs_col[7].msb, obs_col[7].first}), 32'h3);
    check_val("msb_val", 32'(obs_col[7].val), 32'h01);
    check_val("msb_sel", obs_col[7].sel[31:0], 32'h0);

    // Four ones at 3,5,6,7
    for (int v = 0; v < 16; v++) wv[v] = 8'h00;
    wv[3] = 8'h01; wv[5] = 8'h01; wv[6] = 8'h01; wv[7] = 8'h01;
    load();
    consume(exp_q.size(), -1);
    check_val("four_ones_skip0", 32'(obs_col[0].skip[0]), 32'd1);
    check_val("four_ones_val", 32'(obs_col[0].val[3:0]), 32'hF);
    check_val("four_ones_sel", 32'(obs_col[0].sel[11:0]), 32'h923);

    // Six ones -> zeros at 6,7 are encoded
    for (int v = 0; v < 16; v++) wv[v] = (v < 6) ? 8'h01 : 8'h00;
    load();
    consume(exp_q.size(), -1);
    check_val("six_ones_skip0", 32'(obs_col[0].skip[0]), 32'd0);
    check_val("six_ones_val", 32'(obs_col[0].val[3:0]), 32'hC);
    check_val("six_ones_sel", 32'(obs_col[0].sel[11:0]), 32'h900);

    // Backpressure on col 5, then back-to-back accept on the drain beat
    for (int v = 0; v < 16; v++) wv[v] = 8'($urandom);
    wv[0] = wv[0] | 8'h20;
    load();
    consume(exp_q.size() - 1, 5);
    t = 0;
    while (o_col_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    e = exp_q.pop_front();
    check_beat("drain_before_b2b", observe(), e);
    i_col_ready = 1'b0;
    #1;
    check_val("drain_w_ready_stalled", 32'(o_w_ready), 32'd0);
    i_col_ready = 1'b1;
    #1;
    check_val("drain_w_ready_handshake", 32'(o_w_ready), 32'd1);
    for (int v = 0; v < 16; v++) wv[v] = 8'($urandom);
    i_w_valid = 1'b1;
    for (int v = 0; v < 16; v++) i_w_data[v] = wv[v];
    push_vector(wv);
    @(negedge clk);
    i_w_valid = 1'b0;
    check_val("b2b_no_gap_valid", 32'(o_col_valid), 32'd1);
    check_val("b2b_no_gap_first", 32'(o_col_first), 32'd1);
    consume(exp_q.size(), -1);

    // Random vectors
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 16; v++) wv[v] = 8'($urandom);
      load();
      consume(exp_q.size(), -1);
    end

    // All-zero vector
    for (int v = 0; v < 16; v++) wv[v] = 8'h00;
    load();
    consume(exp_q.size(), -1);

    // Reset in the middle of a vector at col 3
    for (int v = 0; v < 16; v++) wv[v] = 8'($urandom);
    wv[1] = 8'hFF;
    load();
    consume(4, -1);
    check_val("mid_reset_at_col3", 32'(o_column_idx), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_reset_col_valid", 32'(o_col_valid), 32'd0);
    check_val("mid_reset_w_ready", 32'(o_w_ready), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("post_reset_idle", 32'(o_col_valid), 32'd0);

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
